mc_control: RTL and testbench

Multi-cycle control unit for the 16-bit TSC CPU. It sequences the shared datapath (single ALU, single memory port, IR/MDR/A/B/ALUOut latches) through fetch, decode, execute, memory and write-back states. In every state it drives the datapath mux selects, write enables, memory handshake and ALU function code. It also maintains the retired-instruction counter and the halt flag.

---
 rtl/mc_control_pkg.sv | 77 +++++++
 rtl/mc_decode.sv | 65 ++++++
 rtl/mc_control.sv | 167 ++++++++++++++++
 tb/tb_mc_control.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_pkg.sv
// Shared encodings for the TSC multi-cycle control unit: ISA opcodes/funcs,
// ALU function codes, FSM states, instruction classes and datapath selects.
package mc_control_pkg;

  localparam logic [3:0] OP_BNE = 4'd0;
  localparam logic [3:0] OP_BEQ = 4'd1;
  localparam logic [3:0] OP_BGZ = 4'd2;
  localparam logic [3:0] OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_ALU = 4'd15;

  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  localparam logic [2:0] FUNC_ADD = 3'd0;
  localparam logic [2:0] FUNC_SUB = 3'd1;
  localparam logic [2:0] FUNC_AND = 3'd2;
  localparam logic [2:0] FUNC_ORR = 3'd3;
  localparam logic [2:0] FUNC_NOT = 3'd4;
  localparam logic [2:0] FUNC_TCP = 3'd5;
  localparam logic [2:0] FUNC_SHL = 3'd6;
  localparam logic [2:0] FUNC_SHR = 3'd7;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_EX_R, S_EX_I, S_EX_M, S_EX_B,
    S_MEM_RD, S_MEM_WR, S_WB_R, S_WB_I, S_WB_M, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    CLS_R_ALU, CLS_IMM, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP,
    CLS_JUMP_LINK, CLS_JREG, CLS_JREG_LINK, CLS_WWD, CLS_HLT, CLS_NOP
  } iclass_t;

  localparam logic [1:0] SRCA_PC   = 2'd0;
  localparam logic [1:0] SRCA_A    = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;

  localparam logic [2:0] SRCB_B    = 3'd0;
  localparam logic [2:0] SRCB_ONE  = 3'd1;
  localparam logic [2:0] SRCB_SEXT = 3'd2;
  localparam logic [2:0] SRCB_ZEXT = 3'd3;
  localparam logic [2:0] SRCB_HI   = 3'd4;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REG    = 2'd3;

  localparam logic [1:0] DST_RT   = 2'd0;
  localparam logic [1:0] DST_RD   = 2'd1;
  localparam logic [1:0] DST_LINK = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  // Decoded instruction: class plus the ALU setup its execute state uses.
  typedef struct packed {
    iclass_t    cls;
    logic [1:0] src_a;
    logic [2:0] src_b;
    logic [2:0] func;
  } dec_t;

  function automatic logic is_alu_func(input logic [5:0] fn);
    return fn[5:3] == 3'b000;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier; also picks the execute-stage ALU
// operands so the FSM never has to look at raw opcode bits.
module mc_decode
  import mc_control_pkg::*;
(
  input  logic [15:0] instr,
  output dec_t        dec
);

  logic [3:0] op;
  logic [5:0] fn;

  assign op = instr[15:12];
  assign fn = instr[5:0];

  always_comb begin
    dec.cls   = CLS_NOP;
    dec.src_a = SRCA_A;
    dec.src_b = SRCB_B;
    dec.func  = FUNC_ADD;
    case (op)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: dec.cls = CLS_BRANCH;
      OP_ADI: begin
        dec.cls   = CLS_IMM;
        dec.src_b = SRCB_SEXT;
      end
      OP_ORI: begin
        dec.cls   = CLS_IMM;
        dec.src_b = SRCB_ZEXT;
        dec.func  = FUNC_ORR;
      end
      OP_LHI: begin
        dec.cls   = CLS_IMM;
        dec.src_a = SRCA_ZERO;
        dec.src_b = SRCB_HI;
      end
      OP_LWD: begin
        dec.cls   = CLS_LOAD;
        dec.src_b = SRCB_SEXT;
      end
      OP_SWD: begin
        dec.cls   = CLS_STORE;
        dec.src_b = SRCB_SEXT;
      end
      OP_JMP: dec.cls = CLS_JUMP;
      OP_JAL: dec.cls = CLS_JUMP_LINK;
      OP_ALU: begin
        if (is_alu_func(fn)) begin
          dec.cls  = CLS_R_ALU;
          dec.func = fn[2:0];
        end else begin
          case (fn)
            FN_JPR:  dec.cls = CLS_JREG;
            FN_JRL:  dec.cls = CLS_JREG_LINK;
            FN_WWD:  dec.cls = CLS_WWD;
            FN_HLT:  dec.cls = CLS_HLT;
            default: dec.cls = CLS_NOP;
          endcase
        end
      end
      default: dec.cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM for the 16-bit TSC CPU: sequences the shared
// datapath, counts retired instructions and holds the halt flag.
module mc_control
  import mc_control_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] instr,
  input  logic        mem_ready,
  input  logic        br_cond,
  output logic        mem_read,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_source,
  output logic [1:0]  alu_src_a,
  output logic [2:0]  alu_src_b,
  output logic [2:0]  func_code,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        output_en,
  output logic        is_halted,
  output logic [15:0] num_inst
);

  state_t      state;
  state_t      state_nx;
  dec_t        dec;
  logic [15:0] num_inst_q;
  logic        retire;
  logic        unused_fields;

  // Register specifiers and immediates are consumed by the datapath only.
  assign unused_fields = ^instr[11:6];

  mc_decode u_decode (
    .instr (instr),
    .dec   (dec)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IF;
      num_inst_q <= '0;
    end else begin
      state <= state_nx;
      if (retire) num_inst_q <= num_inst_q + 16'd1;
    end
  end

  // An instruction retires on the edge that leaves its last state.
  assign retire = ((state_nx == S_IF)   && (state != S_IF)) ||
                  ((state_nx == S_HALT) && (state != S_HALT));

  assign num_inst = reset_n ? num_inst_q : 16'd0;

  always_comb begin
    state_nx   = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = PCSRC_ALU;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_B;
    func_code  = FUNC_ADD;
    reg_write  = 1'b0;
    reg_dst    = DST_RT;
    mem_to_reg = WB_ALUOUT;
    output_en  = 1'b0;
    is_halted  = 1'b0;
    if (reset_n) begin
      case (state)
        S_IF: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = SRCB_ONE;
            state_nx  = S_ID;
          end
        end
        S_ID: begin
          // ALU forms PC+sext(imm) here; it lands in ALUOut as branch target.
          alu_src_b = SRCB_SEXT;
          state_nx  = S_IF;
          case (dec.cls)
            CLS_R_ALU:  state_nx = S_EX_R;
            CLS_IMM:    state_nx = S_EX_I;
            CLS_LOAD,
            CLS_STORE:  state_nx = S_EX_M;
            CLS_BRANCH: state_nx = S_EX_B;
            CLS_JUMP: begin
              pc_write  = 1'b1;
              pc_source = PCSRC_JUMP;
            end
            CLS_JUMP_LINK: begin
              pc_write   = 1'b1;
              pc_source  = PCSRC_JUMP;
              reg_write  = 1'b1;
              reg_dst    = DST_LINK;
              mem_to_reg = WB_PC;
            end
            CLS_JREG: begin
              pc_write  = 1'b1;
              pc_source = PCSRC_REG;
            end
            CLS_JREG_LINK: begin
              pc_write   = 1'b1;
              pc_source  = PCSRC_REG;
              reg_write  = 1'b1;
              reg_dst    = DST_LINK;
              mem_to_reg = WB_PC;
            end
            CLS_WWD:  output_en = 1'b1;
            CLS_HLT:  state_nx  = S_HALT;
            default:  state_nx  = S_IF;
          endcase
        end
        S_EX_R, S_EX_I, S_EX_M: begin
          alu_src_a = dec.src_a;
          alu_src_b = dec.src_b;
          func_code = dec.func;
          if (state == S_EX_R)             state_nx = S_WB_R;
          else if (state == S_EX_I)        state_nx = S_WB_I;
          else if (dec.cls == CLS_STORE)   state_nx = S_MEM_WR;
          else                             state_nx = S_MEM_RD;
        end
        S_EX_B: begin
          pc_write  = br_cond;
          pc_source = PCSRC_ALUOUT;
          state_nx  = S_IF;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          if (mem_ready) state_nx = S_WB_M;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          if (mem_ready) state_nx = S_IF;
        end
        S_WB_R: begin
          reg_write = 1'b1;
          reg_dst   = DST_RD;
          state_nx  = S_IF;
        end
        S_WB_I: begin
          reg_write = 1'b1;
          state_nx  = S_IF;
        end
        S_WB_M: begin
          reg_write  = 1'b1;
          mem_to_reg = WB_MDR;
          state_nx   = S_IF;
        end
        S_HALT: is_halted = 1'b1;
        default: state_nx = S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed cycle-by-cycle bench for mc_control: every control output is
// packed into one vector and compared against hand-built expectations.
module tb_mc_control;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] instr;
  logic        mem_ready;
  logic        br_cond;
  logic        mem_read, mem_write, i_or_d, ir_write, pc_write;
  logic [1:0]  pc_source, alu_src_a;
  logic [2:0]  alu_src_b, func_code;
  logic        reg_write;
  logic [1:0]  reg_dst, mem_to_reg;
  logic        output_en, is_halted;
  logic [15:0] num_inst;
  logic [21:0] ctl;

  int n_chk;
  int n_fail;
  logic [15:0] exp_num;

  always #5 clk = ~clk;

  mc_control dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .instr      (instr),
    .mem_ready  (mem_ready),
    .br_cond    (br_cond),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_source  (pc_source),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .func_code  (func_code),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .output_en  (output_en),
    .is_halted  (is_halted),
    .num_inst   (num_inst)
  );

  assign ctl = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source,
                alu_src_a, alu_src_b, func_code, reg_write, reg_dst,
                mem_to_reg, output_en, is_halted};

  function automatic logic [21:0] mk(input logic mr, mw, iod, irw, pcw,
                                     input logic [1:0] pcs, sa,
                                     input logic [2:0] sb, fc,
                                     input logic rw,
                                     input logic [1:0] rd, m2r,
                                     input logic oe, hlt);
    return {mr, mw, iod, irw, pcw, pcs, sa, sb, fc, rw, rd, m2r, oe, hlt};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge: drive inputs, check, advance one cycle.
  task automatic cyc(input string tag, input logic [15:0] ins, input logic rdy,
                     input logic br, input logic [21:0] exp);
    instr     = ins;
    mem_ready = rdy;
    br_cond   = br;
    #1;
    check(tag, 32'(ctl), 32'(exp));
    @(negedge clk);
  endtask

  task automatic chk_num(input string tag);
    check(tag, 32'(num_inst), 32'(exp_num));
  endtask

  logic [21:0] E_ZERO, E_IFW, E_IF, E_ID, E_EXM, E_ORI, E_LHI, E_SUB, E_WBI,
               E_WBR, E_RD, E_WR, E_WBM, E_BT, E_BN, E_JAL, E_JPR, E_WWD, E_HLT;

  initial begin
    n_chk = 0;
    n_fail = 0;
    exp_num = 16'd0;
    E_ZERO = '0;
    E_IFW = mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0,0);
    E_IF  = mk(1,0,0,1,1, 0,0,1,0, 0,0,0,0,0);
    E_ID  = mk(0,0,0,0,0, 0,0,2,0, 0,0,0,0,0);
    E_EXM = mk(0,0,0,0,0, 0,1,2,0, 0,0,0,0,0);
    E_ORI = mk(0,0,0,0,0, 0,1,3,3, 0,0,0,0,0);
    E_LHI = mk(0,0,0,0,0, 0,2,4,0, 0,0,0,0,0);
    E_SUB = mk(0,0,0,0,0, 0,1,0,1, 0,0,0,0,0);
    E_WBI = mk(0,0,0,0,0, 0,0,0,0, 1,0,0,0,0);
    E_WBR = mk(0,0,0,0,0, 0,0,0,0, 1,1,0,0,0);
    E_RD  = mk(1,0,1,0,0, 0,0,0,0, 0,0,0,0,0);
    E_WR  = mk(0,1,1,0,0, 0,0,0,0, 0,0,0,0,0);
    E_WBM = mk(0,0,0,0,0, 0,0,0,0, 1,0,1,0,0);
    E_BT  = mk(0,0,0,0,1, 1,0,0,0, 0,0,0,0,0);
    E_BN  = mk(0,0,0,0,0, 1,0,0,0, 0,0,0,0,0);
    E_JAL = mk(0,0,0,0,1, 2,0,2,0, 1,2,2,0,0);
    E_JPR = mk(0,0,0,0,1, 3,0,2,0, 0,0,0,0,0);
    E_WWD = mk(0,0,0,0,0, 0,0,2,0, 0,0,0,1,0);
    E_HLT = mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0,1);

    reset_n = 1'b0; instr = 16'h0; mem_ready = 1'b1; br_cond = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ctl", 32'(ctl), 32'd0);
    check("rst_num", 32'(num_inst), 32'd0);
    reset_n = 1'b1;

    // ADI $1,$0,5
    cyc("adi_if", 16'h4105, 1, 0, E_IF);
    cyc("adi_id", 16'h4105, 1, 0, E_ID);
    cyc("adi_ex", 16'h4105, 1, 0, E_EXM);
    chk_num("adi_num_before");
    cyc("adi_wb", 16'h4105, 1, 0, E_WBI);
    exp_num = 16'd1; chk_num("adi_num");

    // LWD $1,0($0) with three wait cycles in the memory state
    cyc("lwd_if", 16'h7100, 1, 0, E_IF);
    cyc("lwd_id", 16'h7100, 1, 0, E_ID);
    cyc("lwd_ex", 16'h7100, 1, 0, E_EXM);
    for (int i = 0; i < 3; i++) cyc("lwd_wait", 16'h7100, 0, 0, E_RD);
    cyc("lwd_rdy", 16'h7100, 1, 0, E_RD);
    cyc("lwd_wb", 16'h7100, 1, 0, E_WBM);
    exp_num = 16'd2; chk_num("lwd_num");

    // BEQ taken, then not taken
    cyc("beq1_if", 16'h1102, 1, 0, E_IF);
    cyc("beq1_id", 16'h1102, 1, 0, E_ID);
    cyc("beq1_ex", 16'h1102, 1, 1, E_BT);
    exp_num = 16'd3; chk_num("beq1_num");
    cyc("beq0_if", 16'h1102, 1, 1, E_IF);
    cyc("beq0_id", 16'h1102, 1, 1, E_ID);
    cyc("beq0_ex", 16'h1102, 1, 0, E_BN);
    exp_num = 16'd4; chk_num("beq0_num");

    // JAL 0x123, then confirm fetch resumes (waiting on memory)
    cyc("jal_if", 16'hA123, 1, 0, E_IF);
    cyc("jal_id", 16'hA123, 1, 0, E_JAL);
    exp_num = 16'd5; chk_num("jal_num");
    cyc("jal_next_ifw", 16'hF6C1, 0, 0, E_IFW);

    // SUB $3,$1,$2
    cyc("sub_if", 16'hF6C1, 1, 0, E_IF);
    cyc("sub_id", 16'hF6C1, 1, 0, E_ID);
    cyc("sub_ex", 16'hF6C1, 1, 0, E_SUB);
    cyc("sub_wb", 16'hF6C1, 1, 0, E_WBR);
    exp_num = 16'd6; chk_num("sub_num");

    // ORI and LHI execute setups
    cyc("ori_if", 16'h5103, 1, 0, E_IF);
    cyc("ori_id", 16'h5103, 1, 0, E_ID);
    cyc("ori_ex", 16'h5103, 1, 0, E_ORI);
    cyc("ori_wb", 16'h5103, 1, 0, E_WBI);
    cyc("lhi_if", 16'h6112, 1, 0, E_IF);
    cyc("lhi_id", 16'h6112, 1, 0, E_ID);
    cyc("lhi_ex", 16'h6112, 1, 0, E_LHI);
    cyc("lhi_wb", 16'h6112, 1, 0, E_WBI);
    exp_num = 16'd8; chk_num("imm_num");

    // WWD, JPR and an undefined opcode: two cycles each
    cyc("wwd_if", 16'hF41C, 1, 0, E_IF);
    cyc("wwd_id", 16'hF41C, 1, 0, E_WWD);
    cyc("jpr_if", 16'hF419, 1, 0, E_IF);
    cyc("jpr_id", 16'hF419, 1, 0, E_JPR);
    cyc("nop_if", 16'hB000, 1, 0, E_IF);
    cyc("nop_id", 16'hB000, 1, 0, E_ID);
    exp_num = 16'd11; chk_num("short_num");

    // SWD with one wait cycle
    cyc("swd_if", 16'h8100, 1, 0, E_IF);
    cyc("swd_id", 16'h8100, 1, 0, E_ID);
    cyc("swd_ex", 16'h8100, 1, 0, E_EXM);
    cyc("swd_wait", 16'h8100, 0, 0, E_WR);
    cyc("swd_rdy", 16'h8100, 1, 0, E_WR);
    exp_num = 16'd12; chk_num("swd_num");

    // Counter wrap: preload as if 65534 instructions had retired
    cyc("wrap_if", 16'hB000, 1, 0, E_IF);
    force dut.num_inst_q = 16'hFFFE;
    #1;
    release dut.num_inst_q;
    cyc("wrap_id", 16'hB000, 1, 0, E_ID);
    exp_num = 16'hFFFF; chk_num("wrap_ffff");
    cyc("wrap2_if", 16'hB000, 1, 0, E_IF);
    cyc("wrap2_id", 16'hB000, 1, 0, E_ID);
    exp_num = 16'd0; chk_num("wrap_zero");

    // HLT parks the FSM until reset
    cyc("hlt_if", 16'hF01D, 1, 0, E_IF);
    cyc("hlt_id", 16'hF01D, 1, 0, E_ID);
    for (int i = 0; i < 20; i++) cyc("halted", 16'hF01D, 1, 1, E_HLT);
    exp_num = 16'd1; chk_num("hlt_num");
    reset_n = 1'b0;
    #1;
    check("hlt_rst_ctl", 32'(ctl), 32'd0);
    check("hlt_rst_num", 32'(num_inst), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_num = 16'd0;

    // Reset while a store waits on memory
    cyc("swr_if", 16'h8100, 1, 0, E_IF);
    cyc("swr_id", 16'h8100, 1, 0, E_ID);
    cyc("swr_ex", 16'h8100, 1, 0, E_EXM);
    cyc("swr_wait", 16'h8100, 0, 0, E_WR);
    reset_n = 1'b0;
    #1;
    check("swr_rst_ctl", 32'(ctl), 32'(E_ZERO));
    @(negedge clk);
    reset_n = 1'b1;
    cyc("swr_after_if", 16'h8100, 0, 0, E_IFW);
    chk_num("swr_num");

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
